spi_regbank_cfg: RTL
====================

// Module: spi_regbank_cfg
// PURPOSE
//  Parametrised SPI register-bank loader for clock-synth/PLL parts (CDCE6200x class).
//  Writes NUM_REGS words from a flattened table, optionally issues an EEPROM-commit word,
//  then reads each register back, compares it under a mask and retries on mismatch.
//  Generates SCLK from clk by a divider; there is no gated clock and only one clock domain.
//  Sits between the board bring-up sequencer and the synth SPI pins.
// PARAMETERS
//  NUM_REGS    8      number of table words written, in order, as index 0..NUM_REGS-1 (max 16)
//  DATA_W      32     bits per SPI frame
//  CLK_DIV     4      SCLK half-period in clk cycles (>=1)
//  LSB_FIRST   1      1: shift bit 0 first; 0: shift bit DATA_W-1 first (applies to TX and RX)
//  WAIT_CYC    60000  idle clk cycles after every write frame, with LE high
//  LE_GAP      4      minimum clk cycles LE is held high between any two frames
//  EEPROM_EN   0      1: send EEPROM_WORD after the table, before readback
//  EEPROM_WORD 32'h1F commit word
//  READBACK    1      1: verify every table word; 0: finish after the writes
//  VMASK       32'hFFFFFFF0  compare mask; the address nibble is excluded
//  MAX_RETRY   2      full-sequence retries after the first attempt before failing
// PORTS
//  clk          in   1                 system clock
//  rst          in   1                 synchronous, active-high reset
//  start        in   1                 one-cycle pulse; starts a sequence; ignored while busy
//  cfg_table    in   NUM_REGS*DATA_W   word i at [i*DATA_W +: DATA_W]; must stay stable while busy
//  spi_clk      out  1                 SCLK, idle low
//  spi_mosi     out  1                 serial data to the device
//  spi_miso     in   1                 serial data from the device
//  spi_le       out  1                 latch enable, active-low frame strobe, idle high
//  spi_syn      out  1                 tied 1
//  spi_powerdn  out  1                 tied 1
//  busy         out  1                 high from the cycle after start until cfg_finish or cfg_error
//  cfg_finish   out  1                 sticky; sequence verified (or written, if READBACK=0)
//  cfg_error    out  1                 sticky; retries exhausted
//  err_index    out  4                 table index of the last mismatch
//  spi_revdata  out  DATA_W            last captured readback word
//  rd_valid     out  1                 one-cycle pulse when spi_revdata updates
// BEHAVIOUR
//  Reset (any state, including mid-frame), next cycle:
//   - spi_le=1, spi_clk=0, spi_mosi=0, busy=0, cfg_finish=0, cfg_error=0
//   - err_index=0, spi_revdata=0, rd_valid=0, retry count=0; state=IDLE
//  A new start after finish or error clears the sticky flags and reruns the sequence.
//  States: IDLE, LOAD, SHIFT, GAP, WAIT, RDCMD, RDSHIFT, CHECK, DONE, FAIL.
//  IDLE -start-> LOAD (idx=0).
//  LOAD: select the next word (table[idx], EEPROM_WORD, or read command); LE goes low; first bit on MOSI.
//  SHIFT, per bit:
//   - SCLK low for CLK_DIV cycles, then high for CLK_DIV cycles
//   - MOSI changes only on the clk where SCLK falls (first bit is valid at LOAD)
//   - MISO is sampled on the clk where SCLK rises
//  After DATA_W bits: SCLK returns low, LE rises. Frame = 2*CLK_DIV*DATA_W cycles of LE low.
//  Write frame -> GAP (LE_GAP) -> WAIT (WAIT_CYC) -> next index.
//  After the table: EEPROM frame if EEPROM_EN, then RDCMD if READBACK, otherwise DONE.
//  RDCMD frame i: word = {0, i[3:0], 4'hE}, followed by GAP.
//  RDSHIFT: DATA_W-bit frame, MOSI=0, MISO shifted in LSB_FIRST order; then spi_revdata
//   loads and rd_valid pulses for one cycle.
//  CHECK:
//   - (rev & VMASK) == (table[i] & VMASK): next i, or DONE after index NUM_REGS-1
//   - mismatch: err_index=i; if retries < MAX_RETRY, retries+1 and back to LOAD with idx=0;
//     otherwise FAIL
//  DONE: cfg_finish=1, busy=0. FAIL: cfg_error=1, busy=0. Both hold until start or rst.
//  start during busy: ignored. start and rst in the same cycle: rst wins.
// TESTING
//  T1 NUM_REGS=2, CLK_DIV=1, LSB_FIRST=1, table={32'h10008F35,32'hE9400300}, READBACK=0
//     -> MOSI bits match the table LSB-first; 64 SCLK rises; cfg_finish=1.
//  T2 LSB_FIRST=0, word 32'h80000001 -> MOSI is 1 on the first and last bit only.
//  T3 Device model echoes the table -> 2 rd_valid pulses; RD cmds 32'h0E and 32'h1E;
//     cfg_finish=1, cfg_error=0.
//  T4 Model corrupts reg1 bit 8 always, MAX_RETRY=2 -> 3 full write passes;
//     cfg_error=1, err_index=1.
//  T5 Model corrupts only bits [3:0] -> masked out; cfg_finish=1.
//  T6 rst asserted mid-SHIFT -> next cycle LE=1, SCLK=0, busy=0;
//     a new start replays from index 0.

Source files
------------

// File: rtl/spi_regbank_cfg.sv
// ---------------------------------------------------------------------------
// spi_regbank_cfg : SPI table loader with optional EEPROM commit, masked readback and retry. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_regbank_cfg #(
   parameter int                NUM_REGS    = 8,
   parameter int                DATA_W      = 32,
   parameter int                CLK_DIV     = 4,
   parameter int                LSB_FIRST   = 1,
   parameter int                WAIT_CYC    = 60000,
   parameter int                LE_GAP      = 4,
   parameter int                EEPROM_EN   = 0,
   parameter logic [DATA_W-1:0] EEPROM_WORD = 'h1F,
   parameter int                READBACK    = 1,
   parameter logic [DATA_W-1:0] VMASK       = 'hFFFF_FFF0,
   parameter int                MAX_RETRY   = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [NUM_REGS*DATA_W-1:0] cfg_table,
   output logic                       spi_clk,
   output logic                       spi_mosi,
   input  logic                       spi_miso,
   output logic                       spi_le,
   output logic                       spi_syn,
   output logic                       spi_powerdn,
   output logic                       busy,
   output logic                       cfg_finish,
   output logic                       cfg_error,
   output logic [3:0]                 err_index,
   output logic [DATA_W-1:0]          spi_revdata,
   output logic                       rd_valid
);

   localparam int              BW        = $clog2(DATA_W + 1);
   localparam int              DW        = $clog2(CLK_DIV + 1);
   localparam logic [BW-1:0]   LAST_BIT  = BW'(DATA_W - 1);
   localparam logic [DW-1:0]   DIV_LAST  = DW'(CLK_DIV - 1);
   localparam logic [3:0]      LAST_IDX  = 4'(NUM_REGS - 1);
   localparam logic [31:0]     GAP_LIM   = 32'(LE_GAP);
   localparam logic [31:0]     WAIT_LIM  = 32'(WAIT_CYC);
   localparam logic [7:0]      RETRY_LIM = 8'(MAX_RETRY);

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD, S_SHIFT, S_GAP, S_WAIT,
      S_RDCMD, S_RDSHIFT, S_CHECK, S_DONE, S_FAIL
   } state_t;

   state_t              state, nxt;
   logic [3:0]          idx;
   logic [7:0]          retry;
   logic [31:0]         cnt;
   logic [DW-1:0]       div_cnt;
   logic [BW-1:0]       bit_cnt;
   logic [DATA_W-1:0]   shreg, rxreg;
   logic                is_ee, is_rdcmd;

   logic [DATA_W-1:0]   words [16];
   logic [DATA_W-1:0]   load_word, shifted, rx_next;
   logic                load_bit, next_bit, match;

   // Pad the table to 16 entries so a 4-bit index always fits.
   for (genvar i = 0; i < 16; i++) begin : g_words
      if (i < NUM_REGS) begin : g_used
         assign words[i] = cfg_table[i*DATA_W +: DATA_W];
      end else begin : g_pad
         assign words[i] = '0;
      end
   end

   always_comb begin
      load_word = (state == S_RDCMD) ? {{(DATA_W-8){1'b0}}, idx, 4'hE}
                : (is_ee ? EEPROM_WORD : words[idx]);
      if (LSB_FIRST != 0) begin
         load_bit = load_word[0];
         shifted  = {1'b0, shreg[DATA_W-1:1]};
         next_bit = shifted[0];
         rx_next  = {spi_miso, rxreg[DATA_W-1:1]};
      end else begin
         load_bit = load_word[DATA_W-1];
         shifted  = {shreg[DATA_W-2:0], 1'b0};
         next_bit = shifted[DATA_W-1];
         rx_next  = {rxreg[DATA_W-2:0], spi_miso};
      end
      match = ((spi_revdata & VMASK) == (words[idx] & VMASK));
   end

   assign spi_syn     = 1'b1;
   assign spi_powerdn = 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         nxt         <= S_IDLE;
         idx         <= '0;
         retry       <= '0;
         cnt         <= '0;
         div_cnt     <= '0;
         bit_cnt     <= '0;
         shreg       <= '0;
         rxreg       <= '0;
         is_ee       <= 1'b0;
         is_rdcmd    <= 1'b0;
         spi_clk     <= 1'b0;
         spi_mosi    <= 1'b0;
         spi_le      <= 1'b1;
         busy        <= 1'b0;
         cfg_finish  <= 1'b0;
         cfg_error   <= 1'b0;
         err_index   <= '0;
         spi_revdata <= '0;
         rd_valid    <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_FAIL: begin
               if (start) begin
                  state      <= S_LOAD;
                  idx        <= '0;
                  retry      <= '0;
                  is_ee      <= 1'b0;
                  busy       <= 1'b1;
                  cfg_finish <= 1'b0;
                  cfg_error  <= 1'b0;
               end
            end
            S_LOAD, S_RDCMD: begin
               shreg    <= load_word;
               spi_mosi <= load_bit;
               spi_le   <= 1'b0;
               div_cnt  <= '0;
               bit_cnt  <= '0;
               is_rdcmd <= (state == S_RDCMD);
               state    <= S_SHIFT;
            end
            S_SHIFT, S_RDSHIFT: begin
               if (div_cnt != DIV_LAST) begin
                  div_cnt <= div_cnt + DW'(1);
               end else begin
                  div_cnt <= '0;
                  if (!spi_clk) begin
                     spi_clk <= 1'b1;
                     rxreg   <= rx_next;
                  end else begin
                     spi_clk <= 1'b0;
                     if (bit_cnt != LAST_BIT) begin
                        bit_cnt  <= bit_cnt + BW'(1);
                        shreg    <= shifted;
                        spi_mosi <= next_bit;
                     end else begin
                        spi_le   <= 1'b1;
                        spi_mosi <= 1'b0;
                        cnt      <= '0;
                        if (state == S_RDSHIFT) begin
                           spi_revdata <= rxreg;
                           rd_valid    <= 1'b1;
                           state       <= S_CHECK;
                        end else begin
                           nxt   <= is_rdcmd ? S_RDSHIFT : S_WAIT;
                           state <= S_GAP;
                        end
                     end
                  end
               end
            end
            S_GAP: begin
               if (cnt + 32'd1 >= GAP_LIM) begin
                  cnt   <= '0;
                  state <= nxt;
                  // The response frame opens straight out of the gap with MOSI held low.
                  if (nxt == S_RDSHIFT) begin
                     spi_le   <= 1'b0;
                     shreg    <= '0;
                     spi_mosi <= 1'b0;
                     div_cnt  <= '0;
                     bit_cnt  <= '0;
                  end
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            S_WAIT: begin
               if (cnt + 32'd1 >= WAIT_LIM) begin
                  cnt <= '0;
                  if (!is_ee && idx != LAST_IDX) begin
                     idx   <= idx + 4'd1;
                     state <= S_LOAD;
                  end else if (!is_ee && EEPROM_EN != 0) begin
                     is_ee <= 1'b1;
                     state <= S_LOAD;
                  end else if (READBACK != 0) begin
                     idx   <= '0;
                     state <= S_RDCMD;
                  end else begin
                     busy       <= 1'b0;
                     cfg_finish <= 1'b1;
                     state      <= S_DONE;
                  end
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            S_CHECK: begin
               cnt <= '0;
               if (match) begin
                  if (idx == LAST_IDX) begin
                     busy       <= 1'b0;
                     cfg_finish <= 1'b1;
                     state      <= S_DONE;
                  end else begin
                     idx   <= idx + 4'd1;
                     nxt   <= S_RDCMD;
                     state <= S_GAP;
                  end
               end else begin
                  err_index <= idx;
                  if (retry < RETRY_LIM) begin
                     retry <= retry + 8'd1;
                     idx   <= '0;
                     is_ee <= 1'b0;
                     nxt   <= S_LOAD;
                     state <= S_GAP;
                  end else begin
                     busy      <= 1'b0;
                     cfg_error <= 1'b1;
                     state     <= S_FAIL;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire
